// File: rtl/cc_bbox_stats_pkg.sv
// rtl/cc_bbox_stats_pkg.sv - shared frame geometry, widths and FSM encodings for cc_bbox_stats
package cc_bbox_stats_pkg;

    localparam int FRAME_WIDTH    = 640;
    localparam int FRAME_HEIGHT   = 480;
    localparam int WORD_SIZE      = 8;
    localparam int BBOX_CNT_WIDTH = 21;

    localparam logic [0:0] BBOX_ACCUM = 1'b0;
    localparam logic [0:0] BBOX_DUMP  = 1'b1;

endpackage

// File: rtl/cc_bbox_stats_if.sv
// rtl/cc_bbox_stats_if.sv - pixel input, record output and status signals of cc_bbox_stats
interface cc_bbox_stats_if #(
    parameter int LABEL_WIDTH = cc_bbox_stats_pkg::WORD_SIZE,
    parameter int COORD_WIDTH = 11,
    parameter int CNT_WIDTH   = cc_bbox_stats_pkg::BBOX_CNT_WIDTH
) ();
    logic                   en;
    logic [31:0]            x;
    logic [31:0]            y;
    logic [LABEL_WIDTH-1:0] label;
    logic                   out_valid;
    logic                   out_ready;
    logic [LABEL_WIDTH-1:0] out_label;
    logic [COORD_WIDTH-1:0] out_min_x;
    logic [COORD_WIDTH-1:0] out_max_x;
    logic [COORD_WIDTH-1:0] out_min_y;
    logic [COORD_WIDTH-1:0] out_max_y;
    logic [CNT_WIDTH-1:0]   out_count;
    logic                   busy;
    logic                   frame_done;
    logic                   overrun;

    modport master (
        output en, x, y, label, out_ready,
        input  out_valid, out_label, out_min_x, out_max_x, out_min_y, out_max_y,
        input  out_count, busy, frame_done, overrun
    );

    modport slave (
        input  en, x, y, label, out_ready,
        output out_valid, out_label, out_min_x, out_max_x, out_min_y, out_max_y,
        output out_count, busy, frame_done, overrun
    );
endinterface

// File: rtl/cc_bbox_stats_bbox_table.sv
// rtl/cc_bbox_stats_bbox_table.sv - per-label bbox/count table; count storage only with BBOX_PIXEL_COUNT_EN
module cc_bbox_stats_bbox_table #(
    parameter int LABEL_WIDTH = 8,
    parameter int COORD_WIDTH = 11,
    parameter int CNT_WIDTH   = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   upd_en,
    input  logic [LABEL_WIDTH-1:0] upd_addr,
    input  logic [COORD_WIDTH-1:0] upd_x,
    input  logic [COORD_WIDTH-1:0] upd_y,
    input  logic [LABEL_WIDTH-1:0] rd_addr,
    output logic                   rd_valid,
    output logic [COORD_WIDTH-1:0] rd_min_x,
    output logic [COORD_WIDTH-1:0] rd_max_x,
    output logic [COORD_WIDTH-1:0] rd_min_y,
    output logic [COORD_WIDTH-1:0] rd_max_y,
    output logic [CNT_WIDTH-1:0]   rd_count
);
    localparam int DEPTH = 1 << LABEL_WIDTH;

    logic [DEPTH-1:0]       r_valid;
    logic [COORD_WIDTH-1:0] r_min_x [DEPTH];
    logic [COORD_WIDTH-1:0] r_max_x [DEPTH];
    logic [COORD_WIDTH-1:0] r_min_y [DEPTH];
    logic [COORD_WIDTH-1:0] r_max_y [DEPTH];
    logic                   w_hit;

    // The update reads the entry it is about to write straight from the flops,
    // so consecutive pixels of the same label always see the latest values.
    assign w_hit    = r_valid[upd_addr];
    assign rd_valid = r_valid[rd_addr];
    assign rd_min_x = r_min_x[rd_addr];
    assign rd_max_x = r_max_x[rd_addr];
    assign rd_min_y = r_min_y[rd_addr];
    assign rd_max_y = r_max_y[rd_addr];

    // Valid bits: set on first touch, all cleared in one cycle at end of dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_valid <= '0;
        else if (clr)    r_valid <= '0;
        else if (upd_en) r_valid[upd_addr] <= 1'b1;
    end

    // Bounding box: seed on first pixel, otherwise widen per axis.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (!w_hit || upd_x < r_min_x[upd_addr]) r_min_x[upd_addr] <= upd_x;
            if (!w_hit || upd_x > r_max_x[upd_addr]) r_max_x[upd_addr] <= upd_x;
            if (!w_hit || upd_y < r_min_y[upd_addr]) r_min_y[upd_addr] <= upd_y;
            if (!w_hit || upd_y > r_max_y[upd_addr]) r_max_y[upd_addr] <= upd_y;
        end
    end

`ifdef BBOX_PIXEL_COUNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    logic [CNT_WIDTH-1:0] r_count [DEPTH];

    assign rd_count = r_count[rd_addr];

    // Pixel count: restart at one on first pixel, saturate at all-ones.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (!w_hit)                          r_count[upd_addr] <= CNT_ONE;
            else if (r_count[upd_addr] != '1)    r_count[upd_addr] <= r_count[upd_addr] + CNT_ONE;
        end
    end
`else
    assign rd_count = '0;
`endif

endmodule

// File: rtl/cc_bbox_stats.sv
// rtl/cc_bbox_stats.sv - per-frame label bbox/count accumulation and record dump (BBOX_PIXEL_COUNT_EN enables counts)
module cc_bbox_stats
    import cc_bbox_stats_pkg::*;
#(
    parameter int LABEL_WIDTH = WORD_SIZE,
    parameter int COORD_WIDTH = 11,
    parameter int FRAME_W     = FRAME_WIDTH,
    parameter int FRAME_H     = FRAME_HEIGHT,
    parameter int CNT_WIDTH   = BBOX_CNT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    cc_bbox_stats_if.slave bus
);
    localparam logic [LABEL_WIDTH:0] PTR_ONE = 1;

    logic [0:0]             r_state;
    logic [LABEL_WIDTH:0]   r_ptr;
    logic                   r_s1_vld;
    logic                   r_s1_last;
    logic [LABEL_WIDTH-1:0] r_s1_label;
    logic [COORD_WIDTH-1:0] r_s1_x;
    logic [COORD_WIDTH-1:0] r_s1_y;
    logic                   r_out_valid;
    logic [LABEL_WIDTH-1:0] r_out_label;
    logic [COORD_WIDTH-1:0] r_out_min_x;
    logic [COORD_WIDTH-1:0] r_out_max_x;
    logic [COORD_WIDTH-1:0] r_out_min_y;
    logic [COORD_WIDTH-1:0] r_out_max_y;
    logic [CNT_WIDTH-1:0]   r_out_count;
    logic                   r_frame_done;
    logic                   r_overrun;

    logic                   w_accept;
    logic                   w_upd_en;
    logic                   w_out_free;
    logic                   w_clr;
    logic                   w_rd_valid;
    logic [COORD_WIDTH-1:0] w_rd_min_x;
    logic [COORD_WIDTH-1:0] w_rd_max_x;
    logic [COORD_WIDTH-1:0] w_rd_min_y;
    logic [COORD_WIDTH-1:0] w_rd_max_y;
    logic [CNT_WIDTH-1:0]   w_rd_count;

    // A pixel following the frame's last pixel (still in S1) already belongs
    // to the dump window and is dropped like any pixel arriving during DUMP.
    assign w_accept   = (r_state == BBOX_ACCUM) && !(r_s1_vld && r_s1_last);
    assign w_upd_en   = r_s1_vld && (r_s1_label != '0);
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_clr      = (r_state == BBOX_DUMP) && r_ptr[LABEL_WIDTH] && w_out_free;

    cc_bbox_stats_bbox_table #(
        .LABEL_WIDTH (LABEL_WIDTH),
        .COORD_WIDTH (COORD_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_table (
        .clk      (clk),
        .rst      (reset),
        .clr      (w_clr),
        .upd_en   (w_upd_en),
        .upd_addr (r_s1_label),
        .upd_x    (r_s1_x),
        .upd_y    (r_s1_y),
        .rd_addr  (r_ptr[LABEL_WIDTH-1:0]),
        .rd_valid (w_rd_valid),
        .rd_min_x (w_rd_min_x),
        .rd_max_x (w_rd_max_x),
        .rd_min_y (w_rd_min_y),
        .rd_max_y (w_rd_max_y),
        .rd_count (w_rd_count)
    );

    // S1 capture of accepted pixels and sticky flag for dropped ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_label <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_s1_vld <= bus.en && w_accept;
            if (bus.en && w_accept) begin
                r_s1_label <= bus.label;
                r_s1_x     <= bus.x[COORD_WIDTH-1:0];
                r_s1_y     <= bus.y[COORD_WIDTH-1:0];
                r_s1_last  <= (bus.x == 32'(FRAME_W - 1)) && (bus.y == 32'(FRAME_H - 1));
            end
            if (bus.en && !w_accept) r_overrun <= 1'b1;
        end
    end

    // ACCUM/DUMP sequencing: scan labels 1..max, emit valid entries, then clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= BBOX_ACCUM;
            r_ptr        <= '0;
            r_out_valid  <= 1'b0;
            r_out_label  <= '0;
            r_out_min_x  <= '0;
            r_out_max_x  <= '0;
            r_out_min_y  <= '0;
            r_out_max_y  <= '0;
            r_out_count  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.out_ready) r_out_valid <= 1'b0;
            case (r_state)
                BBOX_ACCUM: begin
                    if (r_s1_vld && r_s1_last) begin
                        r_state <= BBOX_DUMP;
                        r_ptr   <= PTR_ONE;
                    end
                end
                BBOX_DUMP: begin
                    if (r_ptr[LABEL_WIDTH]) begin
                        if (w_out_free) begin
                            r_state      <= BBOX_ACCUM;
                            r_frame_done <= 1'b1;
                        end
                    end else if (!w_rd_valid) begin
                        r_ptr <= r_ptr + PTR_ONE;
                    end else if (w_out_free) begin
                        r_out_valid <= 1'b1;
                        r_out_label <= r_ptr[LABEL_WIDTH-1:0];
                        r_out_min_x <= w_rd_min_x;
                        r_out_max_x <= w_rd_max_x;
                        r_out_min_y <= w_rd_min_y;
                        r_out_max_y <= w_rd_max_y;
                        r_out_count <= w_rd_count;
                        r_ptr       <= r_ptr + PTR_ONE;
                    end
                end
                default: r_state <= BBOX_ACCUM;
            endcase
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_label  = r_out_label;
    assign bus.out_min_x  = r_out_min_x;
    assign bus.out_max_x  = r_out_max_x;
    assign bus.out_min_y  = r_out_min_y;
    assign bus.out_max_y  = r_out_max_y;
    assign bus.out_count  = r_out_count;
    assign bus.busy       = (r_state == BBOX_DUMP);
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;

endmodule

// File: doc/cc_bbox_stats.md
# cc_bbox_stats

Per-frame object statistics stage directly downstream of the connected-components labeller. It consumes the labelled pixel stream (`cc_out` with its `x`/`y` coordinates) and accumulates a bounding box and pixel count per label. At the end of each frame it drains one record per present label over a valid/ready handshake. The records feed the overlay/host readout logic.

## Interface
Parameters:
- `LABEL_WIDTH`, default 8: label width; equals `WORD_SIZE`.
- `COORD_WIDTH`, default 11: stored coordinate width.
- `FRAME_W`, default `FRAME_WIDTH`: pixels per row.
- `FRAME_H`, default `FRAME_HEIGHT`: rows per frame.
- `CNT_WIDTH`, default 21: pixel-count width; must hold `FRAME_W*FRAME_H`.

Ports (one clock; reset is asynchronous, active-high):
- `clk` in, 1: clock.
- `reset` in, 1: asynchronous, active-high reset.
- `en` in, 1: pixel strobe, same meaning as upstream `en`.
- `x` in, 32: column of the current pixel.
- `y` in, 32: row of the current pixel.
- `label` in, `LABEL_WIDTH`: CC label; 0 is background.
- `out_valid` out, 1: record available.
- `out_ready` in, 1: consumer accepts the record.
- `out_label` out, `LABEL_WIDTH`: label of the record.
- `out_min_x`, `out_max_x`, `out_min_y`, `out_max_y` out, `COORD_WIDTH` each: bounding box, inclusive.
- `out_count` out, `CNT_WIDTH`: pixels carrying the label.
- `busy` out, 1: high while in DUMP.
- `frame_done` out, 1: one-cycle pulse when the dump completes.
- `overrun` out, 1: sticky; set when a pixel is dropped.

## Operation
- Storage: table of 2^`LABEL_WIDTH` entries, each holding {min_x, max_x, min_y, max_y, count}, plus one valid bit per entry. Reads are combinational from flops.
- Input stage S1 registers {`label`, `x[COORD_WIDTH-1:0]`, `y[COORD_WIDTH-1:0]`, last} when `en` is high. `last` = (`x==FRAME_W-1` && `y==FRAME_H-1`).
- Update stage S2 runs the cycle after S1 capture, when the label is nonzero:
  - Invalid entry: load min = max = current coordinate, count = 1, set valid.
  - Valid entry: min/max compare per axis, count += 1, saturating at all-ones.
  - Back-to-back pixels with the same label must update correctly because reads are combinational with no hazard window.
- Label 0 is never written.
- FSM states:
  - ACCUM (reset state): accumulate pixels. When the S2 update carries `last`, go to DUMP and set scan pointer p = 1.
  - DUMP: each cycle examine entry p.
    - If entry p is valid and the output register is free (`!out_valid || out_ready`): load the output registers, assert `out_valid`, increment p.
    - If entry p is invalid: increment p, one entry per cycle.
    - If entry p is valid but the output register is not free: stall.
    - When p has passed the maximum label and the final record has handshaked: clear all valid bits, pulse `frame_done`, return to ACCUM.
- `en` while in DUMP: the pixel is discarded and `overrun` is set. `overrun` clears only on reset.
- Output fields are stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid`=0, `busy`=0, `frame_done`=0, `overrun`=0, all `out_*` data = 0, all valid bits = 0, FSM = ACCUM, S1 empty.
- Pixel to table latency: 2 edges (S1 capture, then S2 write).
- `busy` rises the cycle after the S2 write of the last pixel.
- First `out_valid`: at the earliest 1 cycle after `busy` rises. Each skipped invalid label adds 1 cycle.
- Throughput: 1 record per cycle with `out_ready` held high.
- `frame_done` is asserted in the cycle the FSM returns to ACCUM. `en` is accepted again in that same cycle.
- Reset asserted mid-dump: immediate return to reset state. The partial dump is lost and no `frame_done` is issued.

## Configuration
- `BBOX_PIXEL_COUNT_EN` defined: count storage and increment logic are built; `out_count` is live.
- Undefined: no count storage is built; `out_count` is tied to 0. Bounding-box behaviour is unchanged.

## Structure
- `FRAME_WIDTH`, `FRAME_HEIGHT`, and `WORD_SIZE` come from `global.vh`.
- Add to `global.vh`:
  - FSM state encodings `BBOX_ACCUM` and `BBOX_DUMP`.
  - `BBOX_CNT_WIDTH`.
- One sub-module, `bbox_table`: storage array, valid bits, combinational read port, synchronous update port, and a single-cycle clear-all.

## Test plan
- Single pixel with label 3 at (5,7), then frame end → exactly one record: label=3, box (5,5,7,7), count=1, then `frame_done`.
- Label 2 on pixels (1,1), (4,1), (2,6) sent back-to-back → record: min_x=1, max_x=4, min_y=1, max_y=6, count=3.
- Full frame of label 0 except label 9 at (0,0) → exactly one record (label 9). Label 0 is never emitted.
- Labels 1 and 200 present, `out_ready` held low for 5 cycles →
  - label 1 record stays stable throughout;
  - label 200 follows after the handshake;
  - `frame_done` follows after label 200's handshake.
- `en` pulsed during DUMP → `overrun`=1. The dumped records are unaffected, and the next frame's table starts empty.
- Reset asserted during DUMP → `out_valid`=0, `busy`=0, no `frame_done`. The next frame reports only its own labels.
